// File: rtl/i2s_rx_frame_capture_if.sv
// Stereo frame handshake: head-of-FIFO left/right samples with valid/ready.
interface i2s_rx_frame_capture_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic [SAMPLE_WIDTH-1:0] out_left;
  logic [SAMPLE_WIDTH-1:0] out_right;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output out_left, output out_right, output out_valid, input out_ready);
  modport slave  (input out_left, input out_right, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_rx_frame_capture.sv
// I2S receiver: deserializes L/R slots into a FWFT stereo-frame FIFO; a frame is visible one ACLK after
// its last right bit lands; consumer stalls via out_ready, frames arriving while full are dropped (sticky overflow).
module i2s_rx_frame_capture #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int LVL_W        = 3
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          i2s_bclk,
  input  logic                          i2s_lrclk,
  input  logic                          i2s_sdata,
  i2s_rx_frame_capture_if.master        out_if,
  output logic [LVL_W-1:0]              fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } frame_t;

  logic [2:0]              bclk_sync_q;
  logic [1:0]              lr_sync_q;
  logic [1:0]              sd_sync_q;
  logic                    chan_q, chan_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-2:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic                    left_vld_q, left_vld_d;
  logic [SAMPLE_WIDTH-1:0] sample_w;
  logic                    rise, lr_s, sd_s, push;
  frame_t                  push_dat;

  frame_t                  mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic                    pop, full, wr_en;

  // bclk gets a third stage so a rising edge shows up as a one-cycle pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[0], i2s_lrclk};
      sd_sync_q   <= {sd_sync_q[0], i2s_sdata};
    end
  end

  assign rise     = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lr_s     = lr_sync_q[1];
  assign sd_s     = sd_sync_q[1];
  assign sample_w = {shift_q, sd_s};
  assign push_dat = '{left: left_q, right: sample_w};

  // chan_q doubles as the previous lrclk sample; a change marks the I2S delay bit
  always_comb begin
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    left_d     = left_q;
    left_vld_d = left_vld_q;
    push       = 1'b0;
    if (rise) begin
      if (lr_s != chan_q) begin
        chan_d = lr_s;
        cnt_d  = '0;
        if (!chan_q && cnt_q != CW'(SAMPLE_WIDTH)) left_vld_d = 1'b0;
      end else if (cnt_q != CW'(SAMPLE_WIDTH)) begin
        shift_d = sample_w[SAMPLE_WIDTH-2:0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(SAMPLE_WIDTH - 1)) begin
          if (!chan_q) begin
            left_d     = sample_w;
            left_vld_d = 1'b1;
          end else if (left_vld_q) begin
            push       = 1'b1;
            left_vld_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      chan_q     <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      left_q     <= '0;
      left_vld_q <= 1'b0;
    end else begin
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      left_q     <= left_d;
      left_vld_q <= left_vld_d;
    end
  end

  assign pop   = out_if.out_valid && out_if.out_ready;
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !pop)      level_d = level_q + LVL_W'(1);
    else if (!wr_en && pop) level_d = level_q - LVL_W'(1);
    // a drop in the same cycle as a clear request keeps the flag set
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (clear_overflow)  ovf_d = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage is cleared too so the head reads zero after reset
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign out_if.out_left  = mem_q[rd_ptr_q].left;
  assign out_if.out_right = mem_q[rd_ptr_q].right;
  assign out_if.out_valid = (level_q != '0);
  assign fifo_level       = level_q;
  assign overflow         = ovf_q;
endmodule

// File: tb/tb_i2s_rx_frame_capture.sv
// Directed bench: drives I2S frames at ACLK/8 with 32-bit slots and checks the FIFO output side.
module tb_i2s_rx_frame_capture;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow;
  int          n_tests = 0;
  int          n_fail  = 0;

  i2s_rx_frame_capture_if #(.SAMPLE_WIDTH(24)) out_if ();

  i2s_rx_frame_capture #(.SAMPLE_WIDTH(24), .FIFO_DEPTH(4), .LVL_W(3)) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata),
    .out_if         (out_if),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  vec_t t1 [3];
  vec_t t3 [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // one BCLK period; optionally raise out_ready exactly in the cycle the rise is acted on
  task automatic send_bit(input logic lr, input logic d, input logic rdy_pulse);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = d;
    cyc(4);
    i2s_bclk = 1'b1;
    if (rdy_pulse) begin
      cyc(2);
      out_if.out_ready = 1'b1;
      cyc(1);
      out_if.out_ready = 1'b0;
      cyc(1);
    end else begin
      cyc(4);
    end
  endtask

  // bit 0 is the delay bit (driven with junk), bits 1..24 the sample MSB-first, rest zero
  task automatic send_slot(input logic lr, input logic [23:0] s, input int nbits, input logic rdy_at_push);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)       d = ~s[23];
      else if (i <= 24) d = s[24-i];
      else              d = 1'b0;
      send_bit(lr, d, rdy_at_push && (i == 24));
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic rdy_at_push);
    send_slot(1'b0, l, 32, 1'b0);
    send_slot(1'b1, r, 32, rdy_at_push);
  endtask

  task automatic pop_check(input string name, input logic [23:0] el, input logic [23:0] er);
    check({name, "_valid"}, {63'd0, out_if.out_valid}, 64'd1);
    check({name, "_left"},  {40'd0, out_if.out_left},  {40'd0, el});
    check({name, "_right"}, {40'd0, out_if.out_right}, {40'd0, er});
    out_if.out_ready = 1'b1;
    cyc(1);
    out_if.out_ready = 1'b0;
  endtask

  task automatic check_empty(input string name);
    check({name, "_valid"}, {63'd0, out_if.out_valid}, 64'd0);
    check({name, "_level"}, {61'd0, fifo_level},       64'd0);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    cyc(3);
    ARESETN = 1'b1;
    cyc(1);
  endtask

  initial begin
    t1[0] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
    t1[1] = '{24'h000001, 24'h800000, 24'h000001, 24'h800000};
    t1[2] = '{24'hFFFFFF, 24'h7FFFFF, 24'hFFFFFF, 24'h7FFFFF};
    for (int i = 0; i < 5; i++) begin
      t3[i].l     = 24'h100000 + 24'(i + 1);
      t3[i].r     = 24'h200000 + 24'(i + 1);
      t3[i].exp_l = t3[i].l;
      t3[i].exp_r = t3[i].r;
    end

    ARESETN = 1'b0; i2s_bclk = 1'b0; i2s_lrclk = 1'b1; i2s_sdata = 1'b0;
    out_if.out_ready = 1'b0; clear_overflow = 1'b0;
    cyc(3);
    check_empty("rst");
    check("rst_left",  {40'd0, out_if.out_left},  64'd0);
    check("rst_right", {40'd0, out_if.out_right}, 64'd0);
    check("rst_ovf",   {63'd0, overflow},         64'd0);
    ARESETN = 1'b1;
    cyc(1);

    // 1: three frames queued, then drained in order; short right lead-in aligns the first left slot
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(t1[i].l, t1[i].r, 1'b0);
    cyc(4);
    check("t1_level", {61'd0, fifo_level}, 64'd3);
    for (int i = 0; i < 3; i++) pop_check($sformatf("t1_pop%0d", i), t1[i].exp_l, t1[i].exp_r);
    check_empty("t1_end");

    // 2: start-up mid right slot, that right sample must not form a frame
    do_reset();
    for (int i = 0; i < 28; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_frame(24'h0A0A0A, 24'h050505, 1'b0);
    cyc(4);
    check("t2_level", {61'd0, fifo_level}, 64'd1);
    pop_check("t2_pop", 24'h0A0A0A, 24'h050505);
    check_empty("t2_end");

    // 3: overflow drops frame 5, sticky until cleared
    for (int i = 0; i < 5; i++) send_frame(t3[i].l, t3[i].r, 1'b0);
    cyc(4);
    check("t3_level", {61'd0, fifo_level}, 64'd4);
    check("t3_ovf",   {63'd0, overflow},   64'd1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("t3_pop%0d", i), t3[i].exp_l, t3[i].exp_r);
    check_empty("t3_drained");
    check("t3_ovf_held", {63'd0, overflow}, 64'd1);
    clear_overflow = 1'b1;
    cyc(1);
    clear_overflow = 1'b0;
    check("t3_ovf_clr", {63'd0, overflow}, 64'd0);

    // 4: pop coincident with the push into a full FIFO
    for (int i = 0; i < 4; i++) send_frame(t3[i].l, t3[i].r, 1'b0);
    cyc(4);
    check("t4_full", {61'd0, fifo_level}, 64'd4);
    send_frame(t3[4].l, t3[4].r, 1'b1);
    cyc(4);
    check("t4_level", {61'd0, fifo_level}, 64'd4);
    check("t4_ovf",   {63'd0, overflow},   64'd0);
    for (int i = 1; i < 5; i++) pop_check($sformatf("t4_pop%0d", i), t3[i].exp_l, t3[i].exp_r);
    check_empty("t4_end");

    // 5: short left slot poisons that frame only
    send_slot(1'b0, 24'hDEADBE, 16, 1'b0);
    send_slot(1'b1, 24'h333333, 32, 1'b0);
    send_frame(24'h111111, 24'h222222, 1'b0);
    cyc(4);
    check("t5_level", {61'd0, fifo_level}, 64'd1);
    pop_check("t5_pop", 24'h111111, 24'h222222);
    check_empty("t5_end");

    // 6: asynchronous reset mid left slot with two frames queued
    send_frame(24'h444444, 24'h555555, 1'b0);
    send_frame(24'h666666, 24'h777777, 1'b0);
    cyc(4);
    check("t6_queued", {61'd0, fifo_level}, 64'd2);
    send_slot(1'b0, 24'h888888, 16, 1'b0);
    ARESETN = 1'b0;
    #2;
    check_empty("t6_rst");
    check("t6_rst_left",  {40'd0, out_if.out_left},  64'd0);
    check("t6_rst_right", {40'd0, out_if.out_right}, 64'd0);
    cyc(2);
    ARESETN = 1'b1;
    cyc(1);
    for (int i = 0; i < 16; i++) send_bit(1'b0, 1'b0, 1'b0);
    send_slot(1'b1, 24'h999999, 32, 1'b0);
    send_frame(24'hC0FFEE, 24'h0BADF0, 1'b0);
    cyc(4);
    check("t6_level", {61'd0, fifo_level}, 64'd1);
    pop_check("t6_pop", 24'hC0FFEE, 24'h0BADF0);
    check_empty("t6_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
